// File: rtl/mem_dport_pkg.sv
// mem_dport_pkg: opcodes, funct3 encodings and FSM states for the memory-stage data port
package mem_dport_pkg;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  typedef enum logic [2:0] {sb = 3'b000, sh = 3'b001, sw = 3'b010} store_funct3_t;
  typedef enum logic [2:0] {lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101} load_funct3_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} dport_state_t;
endpackage

// File: rtl/mem_dport_store_align.sv
// mem_dport_store_align: byte enables, lane-shifted store data and misalignment from offset/width
module mem_dport_store_align
  import mem_dport_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2,
  output logic [3:0]  mbe,
  output logic [31:0] wdata,
  output logic        misaligned
);
  logic is_byte, is_half;
  assign is_byte = funct3 inside {sb, lbu};
  assign is_half = funct3 inside {sh, lhu};
  // halves at offset 3 are clipped to the top lane rather than split
  assign mbe = is_byte ? 4'b0001 << off : is_half ? 4'b0011 << off : 4'b1111;
  assign wdata = is_byte ? {4{rs2[7:0]}} : is_half ? 32'(rs2[15:0]) << {off, 3'b000} : rs2;
  assign misaligned = is_byte ? 1'b0 : is_half ? off == 2'd3 : off != 2'd0;
endmodule

// File: rtl/mem_dport.sv
// mem_dport: memory-stage data-cache request holder, handshake FSM and pipeline stall
module mem_dport
  import mem_dport_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] rs2_in,
  input  logic        advance,
  input  logic        flush,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_addr,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_wdata,
  input  logic        data_resp,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic [31:0] r_data_out,
  output logic [3:0]  mbe_out,
  output logic        misaligned,
  output logic        err_timeout
);
  dport_state_t state, state_d;
  logic mem_op, wr_q, kill_q, mis_c;
  logic [3:0] mbe_c;
  logic [31:0] wdata_c, cnt;
  assign mem_op = valid_in && (opcode_in == op_load || opcode_in == op_store) && !flush;
  mem_dport_store_align u_align (
    .off(addr_in[1:0]),
    .funct3(funct3_in),
    .rs2(rs2_in),
    .mbe(mbe_c),
    .wdata(wdata_c),
    .misaligned(mis_c)
  );
  assign data_read = state == REQ && !wr_q;
  assign data_write = state == REQ && wr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        stall = mem_op;
        state_d = mem_op ? REQ : IDLE;
      end
      REQ: begin
        stall = 1'b1;
        // a flushed transaction still completes on the bus, only its result is dropped
        if (data_resp) state_d = (kill_q || flush) ? IDLE : DONE;
      end
      DONE: state_d = advance ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_addr <= '0;
      data_mbe <= '0;
      data_wdata <= '0;
      wr_q <= 1'b0;
      kill_q <= 1'b0;
      misaligned <= 1'b0;
      r_data_out <= '0;
      mbe_out <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && mem_op) begin
        data_addr <= {addr_in[31:2], 2'b00};
        data_mbe <= mbe_c;
        data_wdata <= wdata_c;
        wr_q <= opcode_in == op_store;
        kill_q <= 1'b0;
        misaligned <= mis_c;
      end
      if (state == REQ && flush) kill_q <= 1'b1;
      if (state == REQ && data_resp && !kill_q && !flush) begin
        mbe_out <= data_mbe;
        if (!wr_q) r_data_out <= data_rdata;
      end
      if (TIMEOUT != 0 && state == REQ) begin
        if (data_resp) cnt <= '0;
        else if (cnt != 32'(TIMEOUT)) cnt <= cnt + 32'd1;
        if (!data_resp && cnt == 32'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_dport.sv
// tb_mem_dport: directed checks of alignment, handshake, flush, timeout and async reset
module tb_mem_dport;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_in = 1'b0, advance = 1'b0, flush = 1'b0, data_resp = 1'b0;
  logic [6:0] opcode_in = '0;
  logic [2:0] funct3_in = '0;
  logic [31:0] addr_in = '0, rs2_in = '0, data_rdata = '0;
  logic data_read, data_write, stall, misaligned, err_timeout;
  logic [31:0] data_addr, data_wdata, r_data_out;
  logic [3:0] data_mbe, mbe_out;
  int n_cmp = 0, n_bad = 0, n_stall = 0;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011;

  mem_dport #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .rs2_in(rs2_in), .advance(advance),
    .flush(flush), .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_mbe(data_mbe), .data_wdata(data_wdata), .data_resp(data_resp),
    .data_rdata(data_rdata), .stall(stall), .r_data_out(r_data_out), .mbe_out(mbe_out),
    .misaligned(misaligned), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    valid_in = 1'b1; opcode_in = op; funct3_in = f3; addr_in = a; rs2_in = d;
    #1;
  endtask

  initial begin
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_read", data_read, 0);
    chk("rst_write", data_write, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_rdata", r_data_out, 0);
    chk("rst_mbe_out", mbe_out, 0);
    chk("rst_err", err_timeout, 0);
    #11 rst_n = 1'b1;
    cyc();
    // sb at offset 3
    issue(ST, 3'b000, 32'h1003, 32'hAB);
    chk("sb_stall_idle", stall, 1);
    cyc(); valid_in = 1'b0;
    chk("sb_write", data_write, 1);
    chk("sb_read", data_read, 0);
    chk("sb_addr", data_addr, 32'h1000);
    chk("sb_mbe", data_mbe, 4'b1000);
    chk("sb_wdata", data_wdata, 32'hABABABAB);
    chk("sb_mis", misaligned, 0);
    cyc();
    chk("sb_write_held", data_write, 1);
    chk("sb_stall_req", stall, 1);
    data_resp = 1'b1;
    cyc(); data_resp = 1'b0;
    chk("sb_write_drop", data_write, 0);
    chk("sb_stall_done", stall, 0);
    chk("sb_mbe_out", mbe_out, 4'b1000);
    chk("sb_rdata_kept", r_data_out, 0);
    advance = 1'b1;
    cyc(); advance = 1'b0;
    // sh at offset 2
    issue(ST, 3'b001, 32'h2002, 32'h1234);
    cyc(); valid_in = 1'b0;
    chk("sh2_mbe", data_mbe, 4'b1100);
    chk("sh2_wdata", data_wdata, 32'h12340000);
    chk("sh2_mis", misaligned, 0);
    data_resp = 1'b1;
    cyc(); data_resp = 1'b0; advance = 1'b1;
    cyc(); advance = 1'b0;
    // sh at offset 3: clipped
    issue(ST, 3'b001, 32'h2003, 32'h1234);
    cyc(); valid_in = 1'b0;
    chk("sh3_mbe", data_mbe, 4'b1000);
    chk("sh3_wdata", data_wdata, 32'h34000000);
    chk("sh3_mis", misaligned, 1);
    data_resp = 1'b1;
    cyc(); data_resp = 1'b0; advance = 1'b1;
    cyc(); advance = 1'b0;
    // lw with response in the fifth request cycle
    issue(LD, 3'b010, 32'h3000, 32'h0);
    n_stall = stall ? 1 : 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(); valid_in = 1'b0;
      if (i == 1) chk("lw_read", data_read, 1);
      if (i == 5) begin data_resp = 1'b1; data_rdata = 32'hDEADBEEF; end
      #1;
      n_stall += stall ? 1 : 0;
    end
    cyc(); data_resp = 1'b0;
    chk("lw_stall_cycles", n_stall, 6);
    chk("lw_stall_done", stall, 0);
    chk("lw_rdata", r_data_out, 32'hDEADBEEF);
    chk("lw_mbe_out", mbe_out, 4'b1111);
    chk("lw_read_drop", data_read, 0);
    cyc();
    chk("lw_hold_rdata", r_data_out, 32'hDEADBEEF);
    advance = 1'b1;
    cyc(); advance = 1'b0;
    // lbu flushed in REQ
    issue(LD, 3'b100, 32'h4001, 32'h0);
    cyc(); valid_in = 1'b0;
    chk("lbu_read", data_read, 1);
    chk("lbu_mbe", data_mbe, 4'b0010);
    flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("lbu_read_after_flush", data_read, 1);
    data_resp = 1'b1; data_rdata = 32'h11111111;
    cyc(); data_resp = 1'b0;
    chk("lbu_read_drop", data_read, 0);
    chk("lbu_rdata_kept", r_data_out, 32'hDEADBEEF);
    chk("lbu_mbe_out_kept", mbe_out, 4'b1111);
    // an IDLE FSM stalls combinationally on a new load; DONE would not
    issue(LD, 3'b010, 32'h5000, 32'h0);
    chk("flush_back_idle", stall, 1);
    cyc(); valid_in = 1'b0;
    chk("rst_mid_read_pre", data_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_read", data_read, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_err", err_timeout, 0);
    #3 rst_n = 1'b1;
    issue(ALU, 3'b000, 32'h5000, 32'h0);
    chk("nonmem_stall", stall, 0);
    cyc();
    chk("nonmem_read", data_read, 0);
    chk("nonmem_write", data_write, 0);
    chk("nonmem_stall2", stall, 0);
    valid_in = 1'b0;
    // timeout after 4 unanswered request cycles
    issue(LD, 3'b010, 32'h6000, 32'h0);
    cyc(); valid_in = 1'b0;
    cyc(); cyc(); cyc();
    chk("to_err_early", err_timeout, 0);
    cyc();
    chk("to_err_set", err_timeout, 1);
    chk("to_still_waiting", data_read, 1);
    data_resp = 1'b1; data_rdata = 32'hCAFEF00D;
    cyc(); data_resp = 1'b0;
    chk("to_err_sticky", err_timeout, 1);
    chk("to_rdata", r_data_out, 32'hCAFEF00D);
    chk("to_read_drop", data_read, 0);
    advance = 1'b1;
    cyc(); advance = 1'b0;
    cyc();
    chk("to_err_sticky2", err_timeout, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_dport.md
Name: mem_dport

Overview:
- Memory-stage data-port controller: the store/request side of the load/store path.
- Turns the memory-stage control word, ALU address and rs2 data into a held data-cache request:
  - word-aligned address
  - byte enables
  - lane-shifted write data
- Runs the cache read/write handshake and stalls the pipeline until the response arrives.
- Returns raw read data plus the byte enable to write-back, which performs lane extraction and sign/zero extension.

Parameters:
- TIMEOUT, 0, cycles without data_resp before err_timeout asserts; 0 disables the counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  memory-stage instruction valid
- opcode_in  in  7  rv32i opcode (op_load, op_store act; others pass through)
- funct3_in  in  3  width: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr_in  in  32  ALU-computed effective address
- rs2_in  in  32  store source data
- advance  in  1  downstream accepts the memory-stage result this cycle
- flush  in  1  kill the current instruction
- data_read  out  1  cache read request
- data_write  out  1  cache write request
- data_addr  out  32  {addr[31:2],2'b00}
- data_mbe  out  4  byte enable
- data_wdata  out  32  lane-shifted store data
- data_resp  in  1  cache completion, one-cycle pulse
- data_rdata  in  32  cache read data, valid with data_resp
- stall  out  1  freeze IF..MEM
- r_data_out  out  32  captured raw read word
- mbe_out  out  4  byte enable forwarded to write-back
- misaligned  out  1  access crosses a word boundary
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE
  - all request outputs 0; data_addr, data_mbe, data_wdata, r_data_out, mbe_out 0
  - timeout counter 0; err_timeout 0
- mem_op = valid_in && (opcode_in==op_load || opcode_in==op_store) && !flush.
- Byte enable, with off = addr_in[1:0]:
  - byte: 4'b0001<<off
  - half: off 0 -> 0011, off 1 -> 0110, off 2 -> 1100, off 3 -> 1000 (clipped, misaligned=1)
  - word: 1111; misaligned=1 when off!=0 (address aligned down, no split access)
- Store data:
  - byte: {4{rs2[7:0]}}
  - half: rs2[15:0]<<(8*off), truncated to 32 bits
  - word: rs2
- IDLE:
  - stall = mem_op (combinational).
  - On mem_op, register addr/mbe/wdata and the read/write kind, then go to REQ.
  - Non-memory instructions: stall=0, stay in IDLE.
- REQ:
  - data_read or data_write held high from the registers, stable until data_resp; stall=1.
  - On data_resp: drop the request the same edge, capture data_rdata into r_data_out (loads only; stores leave it unchanged), capture mbe_out, go to DONE.
  - flush in REQ: the transaction is not aborted; set the kill bit, finish the handshake, discard the result, and go to IDLE instead of DONE.
- DONE:
  - stall=0; r_data_out/mbe_out stable.
  - advance=1 -> IDLE. Back-to-back: the next instruction is evaluated in IDLE the following cycle, one bubble minimum.
  - advance=0 -> hold DONE.
- Minimum latency: request visible 1 cycle after mem_op; stall released the cycle after data_resp.
- Timeout (TIMEOUT>0):
  - counter increments each REQ cycle and clears on data_resp.
  - reaching TIMEOUT sets err_timeout (sticky until reset); the FSM keeps waiting.
- data_read and data_write are never high together; both are 0 outside REQ.
- Reset mid-REQ: request drops immediately (asynchronous); no completion is owed.

Decomposition:
- rv32i_types: add store_funct3_t/load_funct3_t enums and a dport_state_t enum {IDLE, REQ, DONE}.
- One combinational sub-module, store_align (addr offset, funct3, rs2 -> mbe, wdata, misaligned), reused by any future second data port.

Test Plan:
- sb, addr=0x1003, rs2=0xAB -> data_addr=0x1000, mbe=1000, wdata=0xABABABAB; data_write held until data_resp; stall drops the next cycle.
- sh, addr=0x2002, rs2=0x1234 -> mbe=1100, wdata=0x12340000; sh at offset 3 -> mbe=1000, misaligned=1.
- lw, addr=0x3000; resp after 5 cycles with rdata=0xDEADBEEF -> stall high 6 cycles, r_data_out=0xDEADBEEF, mbe_out=1111.
- lbu, addr=0x4001; flush asserted while in REQ -> request stays high until resp, no DONE, r_data_out unchanged, returns to IDLE.
- TIMEOUT=4, no resp -> err_timeout=1 after 4 REQ cycles and stays set after a later resp.
- rst_n low during REQ -> data_read=0 immediately (asynchronous); after release, state IDLE and stall=0 for a non-memory opcode.
